// File: rtl/sha256_arb_pkg.sv
// sha256_arb_pkg: shared FSM state type and channel field widths for the
// SHA-256 message-build arbiter.
package sha256_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CFG  = 2'd1,
        DATA = 2'd2
    } arb_state_t;

    localparam int CFG_SIZE_W   = 64;
    localparam int CFG_SCHEME_W = 2;
    localparam int DATA_W       = 512;

endpackage

// File: rtl/sha256_rr_pick.sv
// sha256_rr_pick: combinational round-robin picker. Returns the first set bit
// of req found by searching upward from ptr, wrapping at NUM_REQ.
module sha256_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               any,
    output logic [ID_W-1:0]    idx
);

    logic [ID_W:0] w_pos;

    // Walk offsets from far to near so the nearest requester to ptr wins.
    always_comb begin
        any   = 1'b0;
        idx   = '0;
        w_pos = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_pos = {1'b0, ptr} + (ID_W+1)'(k);
            if (w_pos >= (ID_W+1)'(NUM_REQ)) begin
                w_pos = w_pos - (ID_W+1)'(NUM_REQ);
            end
            if (req[w_pos[ID_W-1:0]]) begin
                any = 1'b1;
                idx = w_pos[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/sha256_message_build_arbiter.sv
// sha256_message_build_arbiter: shares one sha256_message_build between
// NUM_REQ requesters, one packet (cfg beat + data beats to last) per grant,
// round-robin. Forward and ready paths are combinational muxes on grant_id.
// Optional ID side channel: define SHA256_ARB_ID_CHAN_EN.
module sha256_message_build_arbiter
    import sha256_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                              clk,
    input  logic                              nrst,
    input  logic                              en,
    input  logic                              sync_rst,
    input  logic [NUM_REQ*CFG_SIZE_W-1:0]     req_cfg_size,
    input  logic [NUM_REQ*CFG_SCHEME_W-1:0]   req_cfg_scheme,
    input  logic [NUM_REQ-1:0]                req_cfg_last,
    input  logic [NUM_REQ-1:0]                req_cfg_valid,
    output logic [NUM_REQ-1:0]                req_cfg_ready,
    input  logic [NUM_REQ*DATA_W-1:0]         req_data,
    input  logic [NUM_REQ-1:0]                req_data_last,
    input  logic [NUM_REQ-1:0]                req_data_valid,
    output logic [NUM_REQ-1:0]                req_data_ready,
    output logic [CFG_SIZE_W-1:0]             cfg_size,
    output logic [CFG_SCHEME_W-1:0]           cfg_scheme,
    output logic                              cfg_last,
    output logic                              cfg_valid,
    input  logic                              cfg_ready,
    output logic [DATA_W-1:0]                 data_in,
    output logic                              data_in_last,
    output logic                              data_in_valid,
    input  logic                              data_in_ready,
    output logic [ID_W-1:0]                   grant_id,
    output logic                              busy
`ifdef SHA256_ARB_ID_CHAN_EN
    ,
    output logic [ID_W-1:0]                   id_out,
    output logic                              id_out_valid,
    input  logic                              id_out_ready
`endif
);

    arb_state_t             r_state, w_state_nxt;
    logic [ID_W-1:0]        r_grant, w_grant_nxt;
    logic [ID_W-1:0]        r_ptr, w_ptr_nxt;
    logic                   w_any;
    logic [ID_W-1:0]        w_pick;
    logic                   w_id_pend;
    logic [NUM_REQ-1:0]     w_onehot;
    logic [CFG_SIZE_W-1:0]  w_sel_size;
    logic [CFG_SCHEME_W-1:0] w_sel_scheme;
    logic [DATA_W-1:0]      w_sel_data;

    sha256_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req (req_cfg_valid),
        .ptr (r_ptr),
        .any (w_any),
        .idx (w_pick)
    );

    assign w_onehot     = NUM_REQ'(1) << r_grant;
    assign w_sel_size   = req_cfg_size[int'(r_grant)*CFG_SIZE_W +: CFG_SIZE_W];
    assign w_sel_scheme = req_cfg_scheme[int'(r_grant)*CFG_SCHEME_W +: CFG_SCHEME_W];
    assign w_sel_data   = req_data[int'(r_grant)*DATA_W +: DATA_W];
    assign grant_id     = r_grant;
    assign busy         = (r_state != IDLE);

    // State, grant and round-robin pointer; sync_rst behaves like nrst.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_ptr   <= '0;
        end else if (sync_rst) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Next state plus the forward/ready muxes. Everything outward is zero
    // while sync_rst is high; en=0 kills valids/readys and so freezes the FSM.
    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_ptr_nxt      = r_ptr;
        cfg_size       = '0;
        cfg_scheme     = '0;
        cfg_last       = 1'b0;
        cfg_valid      = 1'b0;
        req_cfg_ready  = '0;
        data_in        = '0;
        data_in_last   = 1'b0;
        data_in_valid  = 1'b0;
        req_data_ready = '0;
        if (!sync_rst) begin
            unique case (r_state)
                IDLE: begin
                    if (en && w_any && !w_id_pend) begin
                        w_grant_nxt = w_pick;
                        w_state_nxt = CFG;
                    end
                end
                CFG: begin
                    cfg_size   = w_sel_size;
                    cfg_scheme = w_sel_scheme;
                    cfg_last   = req_cfg_last[r_grant];
                    if (en) begin
                        cfg_valid     = req_cfg_valid[r_grant];
                        req_cfg_ready = w_onehot & {NUM_REQ{cfg_ready}};
                        if (cfg_valid && cfg_ready) begin
                            w_state_nxt = DATA;
                        end
                    end
                end
                DATA: begin
                    data_in      = w_sel_data;
                    data_in_last = req_data_last[r_grant];
                    if (en) begin
                        data_in_valid  = req_data_valid[r_grant];
                        req_data_ready = w_onehot & {NUM_REQ{data_in_ready}};
                        if (data_in_valid && data_in_ready && data_in_last) begin
                            w_state_nxt = IDLE;
                            w_ptr_nxt   = (r_grant == ID_W'(NUM_REQ - 1)) ? '0
                                                                           : r_grant + ID_W'(1);
                        end
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

`ifdef SHA256_ARB_ID_CHAN_EN
    logic r_id_valid;

    // ID beat is raised by the grant and held until the consumer takes it.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_id_valid <= 1'b0;
        end else if (sync_rst) begin
            r_id_valid <= 1'b0;
        end else if (r_state == IDLE && w_state_nxt == CFG) begin
            r_id_valid <= 1'b1;
        end else if (id_out_valid && id_out_ready) begin
            r_id_valid <= 1'b0;
        end
    end

    assign id_out       = r_grant;
    assign id_out_valid = r_id_valid & en & ~sync_rst;
    assign w_id_pend    = r_id_valid;
`else
    assign w_id_pend    = 1'b0;
`endif

endmodule

// File: tb/tb_sha256_message_build_arbiter.sv
// Bench for sha256_message_build_arbiter: directed scenarios plus randomized
// packet traffic checked against a queue-based round-robin reference model.
module tb_sha256_message_build_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic nrst, en, sync_rst;
    logic [N*64-1:0]  req_cfg_size;
    logic [N*2-1:0]   req_cfg_scheme;
    logic [N-1:0]     req_cfg_last, req_cfg_valid, req_cfg_ready;
    logic [N*512-1:0] req_data;
    logic [N-1:0]     req_data_last, req_data_valid, req_data_ready;
    logic [63:0]      cfg_size;
    logic [1:0]       cfg_scheme;
    logic             cfg_last, cfg_valid, cfg_ready;
    logic [511:0]     data_in;
    logic             data_in_last, data_in_valid, data_in_ready;
    logic [IW-1:0]    grant_id;
    logic             busy;
`ifdef SHA256_ARB_ID_CHAN_EN
    logic [IW-1:0]    id_out;
    logic             id_out_valid, id_out_ready;
`endif

    int checks   = 0;
    int failures = 0;

    sha256_message_build_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
        .clk            (clk),
        .nrst           (nrst),
        .en             (en),
        .sync_rst       (sync_rst),
        .req_cfg_size   (req_cfg_size),
        .req_cfg_scheme (req_cfg_scheme),
        .req_cfg_last   (req_cfg_last),
        .req_cfg_valid  (req_cfg_valid),
        .req_cfg_ready  (req_cfg_ready),
        .req_data       (req_data),
        .req_data_last  (req_data_last),
        .req_data_valid (req_data_valid),
        .req_data_ready (req_data_ready),
        .cfg_size       (cfg_size),
        .cfg_scheme     (cfg_scheme),
        .cfg_last       (cfg_last),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .data_in        (data_in),
        .data_in_last   (data_in_last),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .grant_id       (grant_id),
        .busy           (busy)
`ifdef SHA256_ARB_ID_CHAN_EN
        ,
        .id_out         (id_out),
        .id_out_valid   (id_out_valid),
        .id_out_ready   (id_out_ready)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int w = 0; w < 16; w++) r[w*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic set_cfg(input int i, input logic [63:0] sz, input logic [1:0] sc,
                           input logic lst, input logic v);
        req_cfg_size[i*64 +: 64] = sz;
        req_cfg_scheme[i*2 +: 2] = sc;
        req_cfg_last[i]          = lst;
        req_cfg_valid[i]         = v;
    endtask

    task automatic set_data(input int i, input logic [511:0] d, input logic lst, input logic v);
        req_data[i*512 +: 512] = d;
        req_data_last[i]       = lst;
        req_data_valid[i]      = v;
    endtask

    task automatic clear_reqs();
        req_cfg_size = '0; req_cfg_scheme = '0; req_cfg_last = '0; req_cfg_valid = '0;
        req_data = '0; req_data_last = '0; req_data_valid = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nrst = 1'b0; sync_rst = 1'b0; en = 1'b1; cfg_ready = 1'b1; data_in_ready = 1'b1;
`ifdef SHA256_ARB_ID_CHAN_EN
        id_out_ready = 1'b1;
`endif
        clear_reqs();
        tick();
        nrst = 1'b1;
    endtask

    task automatic test_reset();
        nrst = 1'b0; sync_rst = 1'b0; en = 1'b1; cfg_ready = 1'b1; data_in_ready = 1'b1;
`ifdef SHA256_ARB_ID_CHAN_EN
        id_out_ready = 1'b1;
`endif
        clear_reqs();
        for (int i = 0; i < N; i++) begin
            set_cfg(i, {$urandom(), $urandom()}, 2'b11, 1'b1, 1'b1);
            set_data(i, rnd512(), 1'b1, 1'b1);
        end
        @(negedge clk);
        checks++;
        if ({cfg_valid, data_in_valid, busy} !== 3'b000) begin
            failures++;
            $display("FAIL reset_valids got cfg_v=%b data_v=%b busy=%b exp 0", cfg_valid, data_in_valid, busy);
        end
        checks++;
        if (req_cfg_ready !== '0 || req_data_ready !== '0) begin
            failures++;
            $display("FAIL reset_readys got cfg_r=%b data_r=%b exp 0", req_cfg_ready, req_data_ready);
        end
        checks++;
        if (grant_id !== '0) begin
            failures++;
            $display("FAIL reset_grant got=%0d exp=0", grant_id);
        end
        checks++;
        if (cfg_size !== '0 || cfg_scheme !== '0 || data_in !== '0 || cfg_last !== 1'b0 || data_in_last !== 1'b0) begin
            failures++;
            $display("FAIL reset_data got size=%h data_nonzero=%b exp 0", cfg_size, |data_in);
        end
`ifdef SHA256_ARB_ID_CHAN_EN
        checks++;
        if (id_out_valid !== 1'b0 || id_out !== '0) begin
            failures++;
            $display("FAIL reset_id got v=%b id=%0d exp 0", id_out_valid, id_out);
        end
`endif
        clear_reqs();
        tick();
        nrst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || cfg_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle got busy=%b cfg_v=%b exp 0", busy, cfg_valid);
        end
        tick();
    endtask

    task automatic test_single();
        logic [511:0] d0;
        d0 = rnd512();
        do_reset();
        set_cfg(2, 64'h18, 2'b01, 1'b1, 1'b1);
        @(negedge clk);
        checks++;
        if (cfg_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_latency got cfg_v=%b busy=%b exp 0 0", cfg_valid, busy);
        end
        tick();
        @(negedge clk);
        checks++;
        if (grant_id !== 2'd2 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_grant got id=%0d busy=%b exp 2 1", grant_id, busy);
        end
        checks++;
        if (cfg_valid !== 1'b1 || cfg_size !== 64'h18 || cfg_scheme !== 2'b01 || cfg_last !== 1'b1
            || req_cfg_ready !== 4'b0100) begin
            failures++;
            $display("FAIL single_cfg got v=%b size=%h sc=%b last=%b rdy=%b exp 1 18 01 1 0100",
                     cfg_valid, cfg_size, cfg_scheme, cfg_last, req_cfg_ready);
        end
        tick();
        set_cfg(2, 64'h18, 2'b01, 1'b1, 1'b0);
        set_data(2, d0, 1'b1, 1'b1);
        @(negedge clk);
        checks++;
        if (data_in_valid !== 1'b1 || data_in !== d0 || data_in_last !== 1'b1
            || req_data_ready !== 4'b0100 || cfg_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_data got v=%b last=%b rdy=%b match=%b exp 1 1 0100 1",
                     data_in_valid, data_in_last, req_data_ready, data_in === d0);
        end
        tick();
        set_data(2, '0, 1'b0, 1'b0);
        set_cfg(0, 64'h1, 2'b00, 1'b0, 1'b1);
        set_cfg(3, 64'h3, 2'b00, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL single_busy_fall got=%b exp=0", busy);
        end
        tick();
        @(negedge clk);
        checks++;
        if (grant_id !== 2'd3) begin
            failures++;
            $display("FAIL single_rr_ptr got=%0d exp=3", grant_id);
        end
        tick();
    endtask

    task automatic test_stall();
        logic [511:0] d0, d1;
        d0 = rnd512(); d1 = rnd512();
        do_reset();
        set_cfg(1, 64'h40, 2'b10, 1'b0, 1'b1);
        set_cfg(3, 64'h80, 2'b11, 1'b0, 1'b1);
        tick();
        tick();
        set_cfg(1, 64'h40, 2'b10, 1'b0, 1'b0);
        set_data(1, d0, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (grant_id !== 2'd1 || data_in_valid !== 1'b1 || data_in !== d0) begin
            failures++;
            $display("FAIL stall_beat0 got id=%0d v=%b match=%b exp 1 1 1", grant_id, data_in_valid, data_in === d0);
        end
        tick();
        set_data(1, d1, 1'b1, 1'b1);
        data_in_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (req_data_ready !== '0 || data_in_valid !== 1'b1 || data_in !== d1 || grant_id !== 2'd1
                || cfg_valid !== 1'b0 || req_cfg_ready !== '0) begin
                failures++;
                $display("FAIL stall_hold cyc=%0d got drdy=%b v=%b id=%0d cfg_v=%b crdy=%b match=%b exp 0 1 1 0 0 1",
                         c, req_data_ready, data_in_valid, grant_id, cfg_valid, req_cfg_ready, data_in === d1);
            end
            tick();
        end
        data_in_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_data_ready !== 4'b0010) begin
            failures++;
            $display("FAIL stall_release got=%b exp=0010", req_data_ready);
        end
        tick();
        set_data(1, '0, 1'b0, 1'b0);
        tick();
        @(negedge clk);
        checks++;
        if (grant_id !== 2'd3 || cfg_size !== 64'h80) begin
            failures++;
            $display("FAIL stall_next_grant got id=%0d size=%h exp 3 80", grant_id, cfg_size);
        end
        tick();
    endtask

    task automatic test_enable();
        logic [511:0] d0, d1;
        d0 = rnd512(); d1 = rnd512();
        do_reset();
        set_cfg(2, 64'h5, 2'b00, 1'b0, 1'b1);
        tick();
        tick();
        set_cfg(2, 64'h5, 2'b00, 1'b0, 1'b0);
        set_data(2, d0, 1'b0, 1'b1);
        tick();
        set_data(2, d1, 1'b1, 1'b1);
        set_cfg(1, 64'h7, 2'b00, 1'b0, 1'b1);
        en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({cfg_valid, data_in_valid} !== 2'b00 || req_cfg_ready !== '0 || req_data_ready !== '0
                || grant_id !== 2'd2 || busy !== 1'b1) begin
                failures++;
                $display("FAIL en_freeze cyc=%0d got cv=%b dv=%b crdy=%b drdy=%b id=%0d busy=%b exp 0 0 0 0 2 1",
                         c, cfg_valid, data_in_valid, req_cfg_ready, req_data_ready, grant_id, busy);
            end
            tick();
        end
        en = 1'b1;
        @(negedge clk);
        checks++;
        if (data_in_valid !== 1'b1 || data_in !== d1 || grant_id !== 2'd2 || req_data_ready !== 4'b0100) begin
            failures++;
            $display("FAIL en_resume got v=%b id=%0d rdy=%b match=%b exp 1 2 0100 1",
                     data_in_valid, grant_id, req_data_ready, data_in === d1);
        end
        tick();
        clear_reqs();
        tick();
    endtask

    task automatic test_sync_rst();
        do_reset();
        set_cfg(1, 64'h11, 2'b01, 1'b0, 1'b1);
        tick();
        tick();
        set_cfg(1, 64'h11, 2'b01, 1'b0, 1'b0);
        set_data(1, rnd512(), 1'b1, 1'b1);
        tick();
        set_data(1, '0, 1'b0, 1'b0);
        set_cfg(2, 64'h22, 2'b10, 1'b0, 1'b1);
        tick();
        tick();
        set_cfg(2, 64'h22, 2'b10, 1'b0, 1'b0);
        set_data(2, rnd512(), 1'b0, 1'b1);
        sync_rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({cfg_valid, data_in_valid} !== 2'b00 || req_cfg_ready !== '0 || req_data_ready !== '0 || data_in !== '0) begin
            failures++;
            $display("FAIL srst_outputs got cv=%b dv=%b crdy=%b drdy=%b data_nz=%b exp 0",
                     cfg_valid, data_in_valid, req_cfg_ready, req_data_ready, |data_in);
        end
        tick();
        sync_rst = 1'b0;
        clear_reqs();
        set_cfg(1, 64'h33, 2'b00, 1'b0, 1'b1);
        set_cfg(3, 64'h44, 2'b00, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || grant_id !== '0 || cfg_valid !== 1'b0 || data_in_valid !== 1'b0) begin
            failures++;
            $display("FAIL srst_idle got busy=%b id=%0d cv=%b dv=%b exp 0 0 0 0", busy, grant_id, cfg_valid, data_in_valid);
        end
        tick();
        @(negedge clk);
        checks++;
        if (grant_id !== 2'd1 || cfg_size !== 64'h33) begin
            failures++;
            $display("FAIL srst_regrant got id=%0d size=%h exp 1 33", grant_id, cfg_size);
        end
        tick();
    endtask

`ifdef SHA256_ARB_ID_CHAN_EN
    task automatic test_id_chan();
        do_reset();
        id_out_ready = 1'b0;
        set_cfg(1, 64'h9, 2'b00, 1'b0, 1'b1);
        tick();
        @(negedge clk);
        checks++;
        if (id_out_valid !== 1'b1 || id_out !== 2'd1) begin
            failures++;
            $display("FAIL id_rise got v=%b id=%0d exp 1 1", id_out_valid, id_out);
        end
        tick();
        set_cfg(1, 64'h9, 2'b00, 1'b0, 1'b0);
        set_data(1, rnd512(), 1'b1, 1'b1);
        tick();
        set_data(1, '0, 1'b0, 1'b0);
        set_cfg(2, 64'hA, 2'b00, 1'b0, 1'b1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || cfg_valid !== 1'b0 || id_out_valid !== 1'b1 || id_out !== 2'd1) begin
                failures++;
                $display("FAIL id_block cyc=%0d got busy=%b cv=%b idv=%b id=%0d exp 0 0 1 1",
                         c, busy, cfg_valid, id_out_valid, id_out);
            end
            tick();
        end
        id_out_ready = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (id_out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL id_clear got idv=%b busy=%b exp 0 0", id_out_valid, busy);
        end
        tick();
        @(negedge clk);
        checks++;
        if (grant_id !== 2'd2 || busy !== 1'b1 || id_out_valid !== 1'b1 || id_out !== 2'd2) begin
            failures++;
            $display("FAIL id_next_grant got id=%0d busy=%b idv=%b idout=%0d exp 2 1 1 2",
                     grant_id, busy, id_out_valid, id_out);
        end
        tick();
    endtask
`endif

    // mode 0: all four request at once, 2 beats each, requester 0 has two packets.
    // mode 1: random packet counts/lengths, random ready stalls, random en drops.
    task automatic test_traffic(input int mode);
        int npk[N];
        int nbt[N][4];
        logic [63:0]  psz[N][4];
        logic [1:0]   psc[N][4];
        logic         plst[N][4];
        logic [511:0] pdat[N][4][3];
        int exp_req[$];
        int exp_pk[$];
        int rem[N], cur[N], ph[N], bt[N];
        int total, ptr, op, obt, cyc, r, p;
        logic lastx;
        logic [N-1:0] chs, dhs, oh, one;
        do_reset();
        total = 0;
        for (int i = 0; i < N; i++) begin
            npk[i] = (mode == 0) ? ((i == 0) ? 2 : 1) : int'($urandom_range(0, 3));
            for (int q = 0; q < 4; q++) begin
                nbt[i][q]  = (mode == 0) ? 2 : int'($urandom_range(1, 3));
                psz[i][q]  = {$urandom(), $urandom()};
                psc[i][q]  = 2'($urandom_range(0, 3));
                plst[i][q] = 1'($urandom_range(0, 1));
                for (int b = 0; b < 3; b++) pdat[i][q][b] = rnd512();
            end
            total += npk[i];
        end
        if (total == 0) begin
            npk[1] = 1;
            total  = 1;
        end
        // Reference order: every requester with work left is waiting at each
        // decision; take the first one at or after the pointer, wrapping.
        ptr = 0;
        for (int i = 0; i < N; i++) rem[i] = npk[i];
        for (int t = 0; t < total; t++) begin
            int pick;
            pick = -1;
            for (int k = 0; k < N; k++) begin
                if (pick < 0 && rem[(ptr + k) % N] > 0) pick = (ptr + k) % N;
            end
            exp_req.push_back(pick);
            exp_pk.push_back(npk[pick] - rem[pick]);
            rem[pick]--;
            ptr = (pick + 1) % N;
        end
        for (int i = 0; i < N; i++) begin
            cur[i] = 0; ph[i] = 0; bt[i] = 0;
        end
        op = 0; obt = 0; cyc = 0; one = 1;
        while (op < total && cyc < 3000) begin
            for (int i = 0; i < N; i++) begin
                if (cur[i] < npk[i]) begin
                    if (ph[i] == 0) begin
                        set_cfg(i, psz[i][cur[i]], psc[i][cur[i]], plst[i][cur[i]], 1'b1);
                        set_data(i, rnd512(), 1'b1, 1'b0);
                    end else begin
                        set_cfg(i, {$urandom(), $urandom()}, 2'b11, 1'b1, 1'b0);
                        set_data(i, pdat[i][cur[i]][bt[i]], bt[i] == nbt[i][cur[i]] - 1,
                                 (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0));
                    end
                end else begin
                    set_cfg(i, '0, '0, 1'b0, 1'b0);
                    set_data(i, '0, 1'b0, 1'b0);
                end
            end
            if (mode != 0) begin
                cfg_ready     = ($urandom_range(0, 2) != 0);
                data_in_ready = ($urandom_range(0, 2) != 0);
                en            = ($urandom_range(0, 7) != 0);
            end
            @(negedge clk);
            chs = req_cfg_valid & req_cfg_ready;
            dhs = req_data_valid & req_data_ready;
            oh  = one << grant_id;
            checks++;
            if (!en) begin
                if ({cfg_valid, data_in_valid} !== 2'b00 || req_cfg_ready !== '0 || req_data_ready !== '0) begin
                    failures++;
                    $display("FAIL traffic_en_off got cv=%b dv=%b crdy=%b drdy=%b exp 0",
                             cfg_valid, data_in_valid, req_cfg_ready, req_data_ready);
                end
            end else if (((req_cfg_ready | req_data_ready) & ~oh) !== '0) begin
                failures++;
                $display("FAIL traffic_ungranted_ready got crdy=%b drdy=%b grant=%0d",
                         req_cfg_ready, req_data_ready, grant_id);
            end
            if (cfg_valid && cfg_ready) begin
                checks++;
                if (op >= total) begin
                    failures++;
                    $display("FAIL traffic_extra_cfg got req=%0d exp none", grant_id);
                end else begin
                    r = exp_req[op]; p = exp_pk[op];
                    if (grant_id !== IW'(r) || cfg_size !== psz[r][p] || cfg_scheme !== psc[r][p]
                        || cfg_last !== plst[r][p]) begin
                        failures++;
                        $display("FAIL traffic_cfg pkt=%0d got req=%0d size=%h sc=%b last=%b exp req=%0d size=%h sc=%b last=%b",
                                 op, grant_id, cfg_size, cfg_scheme, cfg_last, r, psz[r][p], psc[r][p], plst[r][p]);
                    end
                end
                obt = 0;
            end
            if (data_in_valid && data_in_ready) begin
                checks++;
                if (op >= total) begin
                    failures++;
                    $display("FAIL traffic_extra_data got req=%0d exp none", grant_id);
                end else begin
                    r = exp_req[op]; p = exp_pk[op];
                    lastx = (obt == nbt[r][p] - 1);
                    if (grant_id !== IW'(r) || data_in !== pdat[r][p][obt] || data_in_last !== lastx) begin
                        failures++;
                        $display("FAIL traffic_data pkt=%0d beat=%0d got req=%0d last=%b match=%b exp req=%0d last=%b",
                                 op, obt, grant_id, data_in_last, data_in === pdat[r][p][obt], r, lastx);
                    end
                    if (lastx) begin
                        op++;
                        obt = 0;
                    end else begin
                        obt++;
                    end
                end
            end
            tick();
            for (int i = 0; i < N; i++) begin
                if (chs[i]) begin
                    ph[i] = 1;
                    bt[i] = 0;
                end
                if (dhs[i]) begin
                    if (bt[i] == nbt[i][cur[i]] - 1) begin
                        cur[i]++;
                        ph[i] = 0;
                    end else begin
                        bt[i]++;
                    end
                end
            end
            cyc++;
        end
        checks++;
        if (op !== total) begin
            failures++;
            $display("FAIL traffic_done mode=%0d got packets=%0d exp=%0d", mode, op, total);
        end
        clear_reqs();
        en = 1'b1; cfg_ready = 1'b1; data_in_ready = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_traffic(0);
        test_stall();
        test_enable();
        test_sync_rst();
`ifdef SHA256_ARB_ID_CHAN_EN
        test_id_chan();
`endif
        for (int n = 0; n < 6; n++) test_traffic(1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
